// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache, one word per line.
//
// Sits between the datapath instruction port and the memory controller.
// Lookups are combinational. A miss latches the word address and holds
// iREN until the memory drops iwait, then fills the indexed set and
// returns to IDLE. The next IDLE cycle then hits from the array.
//
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   imemREN, imemaddr  datapath read request / byte address ([1:0] ignored)
//   ihit, imemload     hit strobe / instruction word (0 when no hit)
//   iREN, iaddr        memory read request / word address
//   iwait, iload       memory busy / read data (valid when iREN & ~iwait)
//
// Parameters:
//   SETS  number of one-word lines (power of two, >= 2)
//
// Build option:
//   ICACHE_FILL_FORWARD_EN  when defined, the fill word is forwarded to
//                           ihit/imemload in the completing FETCH cycle,
//                           provided the datapath still requests the
//                           missed address.
module icache_dm #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]       state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             lookup, fill;

  assign idx      = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];

  // Byte offset within the word plays no part in a word-granular cache.
  logic unused_ok;
  assign unused_ok = ^imemaddr[1:0];

  assign lookup = imemREN & valid[idx] & (tags[idx] == req_tag);
  assign fill   = (state == FETCH) & ~iwait;

  // Control state and valid bits. Reset drops state to IDLE, so a fetch
  // caught by reset never reaches the fill below.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      case (state)
        IDLE: if (imemREN && !lookup) begin
          miss_addr <= {imemaddr[31:2], 2'b00};
          state     <= FETCH;
        end
        default: if (!iwait) begin
          valid[miss_idx] <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

  // Tag/data storage is qualified by valid, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (state == IDLE) begin
      ihit     = lookup;
      imemload = lookup ? data[idx] : '0;
    end else begin
      iREN  = 1'b1;
      iaddr = miss_addr;
`ifdef ICACHE_FILL_FORWARD_EN
      // The array is not written until the edge, so serve the word
      // straight from the memory bus in the completing cycle.
      if (!iwait && imemREN && ({imemaddr[31:2], 2'b00} == miss_addr)) begin
        ihit     = 1'b1;
        imemload = iload;
      end
`endif
    end
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache.
- Acts as the responder on the datapath instruction port: accepts imemREN/imemaddr from the pipeline and returns ihit/imemload.
- On a miss, fetches one word from the memory controller through an iREN/iaddr/iwait/iload handshake.
- Sits between the pipelined datapath and the memory controller, one instance per core.

Parameters:
SETS, 16, number of one-word lines; power of two, at least 2; IDX_W = log2(SETS).

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, asynchronous, active-low
imemREN  input  1  datapath instruction read request
imemaddr  input  32  datapath instruction byte address; bits [1:0] ignored
ihit  output  1  requested word is valid on imemload this cycle
imemload  output  32  instruction word; 0 when ihit=0
iREN  output  1  memory read request
iaddr  output  32  memory word address, {addr[31:2],2'b00}
iwait  input  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0
iload  input  32  memory read data

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2].
- Storage per set: valid bit, tag, 32-bit data word.
- Reset (nRST=0, asynchronous):
  - all valid bits cleared; FSM to IDLE; latched miss address cleared to 0.
  - iREN=0, iaddr=0, ihit=0, imemload=0.
  - tag and data arrays need not be reset.
- Hit (combinational): ihit = imemREN & valid[index] & (tag[index]==tag(imemaddr)), in the same cycle as the request. imemload = data[index] when ihit=1, else 0.
- FSM states: IDLE, FETCH.
  - IDLE: ihit as above; iREN=0, iaddr=0. If imemREN=1 and no hit, latch {imemaddr[31:2],2'b00} into miss_addr; next state FETCH.
  - FETCH: iREN=1, iaddr=miss_addr; ihit=0 unless the optional feature applies.
    - iwait=1: stay in FETCH.
    - iwait=0: at the clock edge write data[idx(miss_addr)]=iload, tag=tag(miss_addr), valid=1; next state IDLE.
- Miss latency: miss seen in cycle 0; FETCH from cycle 1. Memory holds iwait=1 for W cycles, then 0 for one cycle. The hit is reported in cycle W+2 if imemaddr is unchanged.
- Replacement: a fill always overwrites the indexed set, whatever its prior contents.
- imemaddr changes during FETCH (datapath flush or branch redirect): the fetch completes for the latched miss_addr and that line is filled. The new address is then looked up in IDLE on the following cycle.
- imemREN drops during FETCH: the fetch completes and the line is filled; no ihit is generated.
- Reset asserted mid-FETCH: the fetch is abandoned; iREN=0 immediately (asynchronous); no line is written.
- No write path; imemload never changes due to data-side traffic.
- Only one outstanding miss at a time; no new miss is latched while in FETCH.

Optional Feature:
Macro ICACHE_FILL_FORWARD_EN.
- Defined: in a FETCH cycle with iwait=0, imemREN=1 and {imemaddr[31:2],2'b00}==miss_addr:
  - ihit=1 and imemload=iload in that same cycle;
  - the fill still happens at the edge;
  - miss latency becomes W+1.
- Not defined: ihit=0 throughout FETCH; the first hit comes from the array in IDLE (latency W+2).

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x00000004, memory iwait=1 for 3 cycles then iload=0x8C220000 -> iREN=1, iaddr=0x00000004 in cycles 1-4; ihit=1, imemload=0x8C220000 in cycle 5 (cycle 4 with ICACHE_FILL_FORWARD_EN).
- Warm hit: after the cold fill, request 0x00000004 again -> ihit=1 in the same cycle, iREN stays 0.
- Conflict (SETS=16): fill 0x00000000 (data 0x11111111), then 0x00000040 (data 0x22222222), then re-request 0x00000000 -> third access misses, iaddr=0x00000000, refill with 0x11111111.
- Redirect mid-fetch: miss on 0x00000010, change imemaddr to 0x00000100 while iwait=1 -> iaddr stays 0x00000010 until iwait=0. Next IDLE cycle misses on 0x00000100; 0x00000010 then hits.
- Reset mid-fetch: assert nRST=0 during FETCH -> iREN=0 and ihit=0 asynchronously; after release the same address misses again (valid cleared).
- imemREN drop mid-fetch: deassert imemREN during FETCH -> fill completes and ihit stays 0; a later request to that address hits immediately.
